// File: rtl/fma_sum_lzc_stage.sv
// fma_sum_lzc_stage
//
// Adder stage of the single-precision FMA datapath. It sits directly behind
// the addend pre-normalizer. The stage adds the pre-aligned addend frame
// (already inverted when subtracting) to the B*C mantissa product. It then
// resolves the end-around sign and hands the normalizer a positive magnitude,
// plus an optional leading-zero count.
//
// The stage is a two-deep valid/ready pipeline:
//   S1 : 75-bit add with carry-in, registered together with the side data
//   S2 : sign resolution, magnitude, zero detect and LZC; all outputs are
//        registered here
//
// Optional feature macro: FMA_SUM_LZC_EN
//   defined   : Lzc_o carries the leading-zero count of Mant_o
//               (0..74, counted from bit 73; 74 when Mant_o is 0)
//   undefined : the LZC logic is removed and Lzc_o is tied to 0. The
//               normalizer then counts on its own.
//
// Ports
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   In_valid_i        input beat valid
//   In_ready_o        stage can accept a beat this cycle
//   Sign_aligned_i    sign of the aligned result frame
//   Exp_aligned_i     aligned exponent (PARM_EXP+2 bits)
//   A_Mant_aligned_i  addend frame; bit 74 = effective subtract
//   Sticky_i          sticky from addend alignment
//   Product_i         B*C mantissa product (2*(PARM_MANT+1) bits)
//   Out_valid_o       output beat valid
//   Out_ready_i       downstream accepts
//   Sign_o            result sign (forced to 0 on an exact zero)
//   Exp_o             passed-through aligned exponent
//   Mant_o            result magnitude (74 bits)
//   Lzc_o             leading zeros of Mant_o
//   Sticky_o          passed-through sticky
//   Zero_o            exact-zero result
module fma_sum_lzc_stage #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  In_valid_i,
  output logic                  In_ready_o,
  input  logic                  Sign_aligned_i,
  input  logic [PARM_EXP+1:0]   Exp_aligned_i,
  input  logic [74:0]           A_Mant_aligned_i,
  input  logic                  Sticky_i,
  input  logic [2*(PARM_MANT+1)-1:0] Product_i,
  output logic                  Out_valid_o,
  input  logic                  Out_ready_i,
  output logic                  Sign_o,
  output logic [PARM_EXP+1:0]   Exp_o,
  output logic [73:0]           Mant_o,
  output logic [6:0]            Lzc_o,
  output logic                  Sticky_o,
  output logic                  Zero_o
);

  localparam int FRAME_W = 75;
  localparam int MAG_W   = 74;
  localparam int PROD_W  = 2 * (PARM_MANT + 1);

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic                 s1_valid;
  logic                 s1_load;
  logic                 s2_load;

  // S2 takes a beat whenever S1 holds one and the output slot is free or
  // being drained this cycle. S1 can take a new beat when it is empty, or
  // when its current beat moves on. That path runs combinationally from
  // Out_ready_i. In_valid_i never feeds back into In_ready_o.
  assign s2_load    = s1_valid & (~Out_valid_o | Out_ready_i);
  assign In_ready_o = ~s1_valid | s2_load;
  assign s1_load    = In_valid_i & In_ready_o;

  // ---------------------------------------------------------------------
  // S1 : add
  // ---------------------------------------------------------------------
  logic                 sub;
  logic                 cin;
  logic [FRAME_W-1:0]   prod_ext;
  logic [FRAME_W-1:0]   sum_d;

  logic [FRAME_W-1:0]   s1_sum;
  logic                 s1_sign;
  logic [PARM_EXP+1:0]  s1_exp;
  logic                 s1_sticky;

  // The +1 completes the two's complement of an inverted addend. It is
  // withheld when sticky bits were shifted out: the true addend is then
  // slightly larger in magnitude than the frame shows. The result sits
  // just below the exact value, and sticky records the difference.
  assign sub      = A_Mant_aligned_i[FRAME_W-1];
  assign cin      = sub & ~Sticky_i;
  assign prod_ext = {{(FRAME_W-PROD_W){1'b0}}, Product_i};
  assign sum_d    = A_Mant_aligned_i + prod_ext + {{(FRAME_W-1){1'b0}}, cin};

  // S1 valid flag plus data registers. The data only loads with an accepted
  // beat, so bubbles leave the registers untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_sticky <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s1_load) begin
        s1_sum    <= sum_d;
        s1_sign   <= Sign_aligned_i;
        s1_exp    <= Exp_aligned_i;
        s1_sticky <= Sticky_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2 : resolve sign, magnitude, zero
  // ---------------------------------------------------------------------
  logic                 neg;
  logic [MAG_W-1:0]     mag_d;
  logic                 zero_d;
  logic                 sign_d;

  // A set top bit means the frame went negative (the addend dominated the
  // subtraction). Negating gives the magnitude and flips the sign. An
  // exact zero is reported as +0. A zero magnitude with sticky set is not
  // exact, so it is not reported as zero.
  assign neg    = s1_sum[FRAME_W-1];
  assign mag_d  = neg ? (~s1_sum[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, 1'b1})
                      : s1_sum[MAG_W-1:0];
  assign zero_d = (mag_d == '0) & ~s1_sticky;
  assign sign_d = zero_d ? 1'b0 : (s1_sign ^ neg);

`ifdef FMA_SUM_LZC_EN
  // Leading-zero count over the 74-bit magnitude. The magnitude is padded
  // with two low zeros, giving 19 nibbles. The first non-zero nibble from
  // the top gives the coarse count; a small priority encoder inside that
  // nibble gives the rest. The padding never produces a count above 73
  // for a non-zero magnitude, so 74 stays reserved for Mant == 0.
  function automatic logic [6:0] nibble_lz(input logic [3:0] nib);
    logic [6:0] n;
    casez (nib)
      4'b1???: n = 7'd0;
      4'b01??: n = 7'd1;
      4'b001?: n = 7'd2;
      default: n = 7'd3;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] count_lz(input logic [MAG_W-1:0] mag);
    logic [MAG_W+1:0] padded;
    logic [3:0]       nib;
    logic [6:0]       count;
    logic             found;
    padded = {mag, 2'b00};
    count  = 7'd74;
    found  = 1'b0;
    for (int g = 0; g < (MAG_W + 2) / 4; g++) begin
      nib = padded[MAG_W + 1 - 4*g -: 4];
      if (!found && (nib != 4'd0)) begin
        found = 1'b1;
        count = 7'(4*g) + nibble_lz(nib);
      end
    end
    return count;
  endfunction

  logic [6:0] lzc_d;
  logic [6:0] lzc_q;

  assign lzc_d = count_lz(mag_d);
  assign Lzc_o = lzc_q;

  // The count register follows the same load and reset rules as the
  // other output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lzc_q <= 7'd0;
    end else if (s2_load) begin
      lzc_q <= lzc_d;
    end
  end
`else
  assign Lzc_o = 7'd0;
`endif

  // Output valid flag plus output registers. A beat loaded into S2 stays
  // put until downstream takes it, so the outputs are stable under
  // backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      Out_valid_o <= 1'b0;
      Sign_o      <= 1'b0;
      Exp_o       <= '0;
      Mant_o      <= '0;
      Sticky_o    <= 1'b0;
      Zero_o      <= 1'b0;
    end else begin
      if (s2_load) begin
        Out_valid_o <= 1'b1;
      end else if (Out_ready_i) begin
        Out_valid_o <= 1'b0;
      end
      if (s2_load) begin
        Sign_o   <= sign_d;
        Exp_o    <= s1_exp;
        Mant_o   <= mag_d;
        Sticky_o <= s1_sticky;
        Zero_o   <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_fma_sum_lzc_stage.sv
// tb_fma_sum_lzc_stage
//
// Bench for fma_sum_lzc_stage. Expected results come from a reference
// model that works on plain integer arithmetic:
//   - the signed 75-bit sum
//   - its absolute value
//   - a bit scan for the leading zeros
// A small occupancy model predicts In_ready_o: a two-entry pipeline is full
// only when it holds two beats and downstream stalls.
module tb_fma_sum_lzc_stage;

  localparam int PARM_EXP  = 8;
  localparam int PARM_MANT = 23;

`ifdef FMA_SUM_LZC_EN
  localparam bit LZC_ON = 1'b1;
`else
  localparam bit LZC_ON = 1'b0;
`endif

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [73:0] mant;
    logic [6:0]  lzc;
    logic        sticky;
    logic        zero;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        In_valid_i;
  logic        In_ready_o;
  logic        Sign_aligned_i;
  logic [9:0]  Exp_aligned_i;
  logic [74:0] A_Mant_aligned_i;
  logic        Sticky_i;
  logic [47:0] Product_i;
  logic        Out_valid_o;
  logic        Out_ready_i;
  logic        Sign_o;
  logic [9:0]  Exp_o;
  logic [73:0] Mant_o;
  logic [6:0]  Lzc_o;
  logic        Sticky_o;
  logic        Zero_o;

  int checks = 0;
  int fails  = 0;

  fma_sum_lzc_stage #(
    .PARM_EXP  (PARM_EXP),
    .PARM_MANT (PARM_MANT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .In_valid_i       (In_valid_i),
    .In_ready_o       (In_ready_o),
    .Sign_aligned_i   (Sign_aligned_i),
    .Exp_aligned_i    (Exp_aligned_i),
    .A_Mant_aligned_i (A_Mant_aligned_i),
    .Sticky_i         (Sticky_i),
    .Product_i        (Product_i),
    .Out_valid_o      (Out_valid_o),
    .Out_ready_i      (Out_ready_i),
    .Sign_o           (Sign_o),
    .Exp_o            (Exp_o),
    .Mant_o           (Mant_o),
    .Lzc_o            (Lzc_o),
    .Sticky_o         (Sticky_o),
    .Zero_o           (Zero_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: treat the modular 75-bit sum as a signed number and
  // take its absolute value.
  function automatic exp_t model(input logic [74:0] a, input logic [47:0] p,
                                 input logic s, input logic [9:0] e,
                                 input logic st);
    exp_t        r;
    logic [75:0] total;
    logic [75:0] sum;
    logic [75:0] mag;
    total = {1'b0, a} + {28'b0, p} + ((a[74] && !st) ? 76'd1 : 76'd0);
    sum   = {1'b0, total[74:0]};
    if (sum >= (76'd1 << 74)) begin
      mag    = (76'd1 << 75) - sum;
      r.sign = ~s;
    end else begin
      mag    = sum;
      r.sign = s;
    end
    r.mant   = mag[73:0];
    r.exp    = e;
    r.sticky = st;
    r.zero   = (r.mant == 74'd0) && !st;
    if (r.zero) r.sign = 1'b0;
    r.lzc = 7'd0;
    if (LZC_ON) begin
      r.lzc = 7'd74;
      for (int i = 0; i < 74; i++) if (r.mant[i]) r.lzc = 7'(73 - i);
    end
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g = {Sign_o, Exp_o, Mant_o, Lzc_o, Sticky_o, Zero_o};
    return g;
  endfunction

  // Random data with a bias toward cancellation and near-cancellation.
  task automatic gen_random();
    logic [95:0] ra;
    logic [95:0] rp;
    int          mode;
    ra   = {$urandom(), $urandom(), $urandom()};
    rp   = {$urandom(), $urandom(), $urandom()};
    mode = int'($urandom_range(0, 3));
    Product_i = rp[47:0];
    case (mode)
      0:       A_Mant_aligned_i = ra[74:0];
      1:       A_Mant_aligned_i = {1'b1, ~{26'b0, rp[47:0]}};
      2:       A_Mant_aligned_i = {1'b1, ~({26'b0, rp[47:0]} + 74'(ra[1:0]))};
      default: A_Mant_aligned_i = {27'b0, ra[47:0]};
    endcase
    Sign_aligned_i = ra[80];
    Exp_aligned_i  = ra[90:81];
    Sticky_i       = ($urandom_range(0, 3) == 0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    In_valid_i = 1'b0; Out_ready_i = 1'b0;
    Sign_aligned_i = 1'b0; Exp_aligned_i = '0; A_Mant_aligned_i = '0;
    Sticky_i = 1'b0; Product_i = '0;
    #2;
    checks++;
    if ({Out_valid_o, observed()} !== 95'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {Out_valid_o, observed()});
    end
    #20 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (In_ready_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", In_ready_o);
    end
  endtask

  task automatic test_directed();
    logic [73:0] one46;
    logic [74:0] a_tab [4];
    logic [47:0] p_tab [4];
    logic        s_tab [4];
    logic        st_tab[4];
    logic [73:0] m_exp [4];
    logic [6:0]  l_exp [4];
    logic        sg_exp[4];
    logic        z_exp [4];
    logic [9:0]  e_in;
    one46 = 74'h1 << 46;
    a_tab[0] = '0;                p_tab[0] = 48'h4000_0000_0000; s_tab[0] = 1'b1; st_tab[0] = 1'b0;
    a_tab[1] = {1'b1, ~one46};    p_tab[1] = 48'h4000_0000_0000; s_tab[1] = 1'b1; st_tab[1] = 1'b0;
    a_tab[2] = {1'b1, ~one46};    p_tab[2] = 48'h2000_0000_0000; s_tab[2] = 1'b0; st_tab[2] = 1'b0;
    a_tab[3] = {1'b1, ~one46};    p_tab[3] = 48'h4000_0000_0000; s_tab[3] = 1'b0; st_tab[3] = 1'b1;
    m_exp[0] = 74'h1 << 46; l_exp[0] = 7'd27; sg_exp[0] = 1'b1; z_exp[0] = 1'b0;
    m_exp[1] = 74'h0;       l_exp[1] = 7'd74; sg_exp[1] = 1'b0; z_exp[1] = 1'b1;
    m_exp[2] = 74'h1 << 45; l_exp[2] = 7'd28; sg_exp[2] = 1'b1; z_exp[2] = 1'b0;
    m_exp[3] = 74'h1;       l_exp[3] = 7'd73; sg_exp[3] = 1'b1; z_exp[3] = 1'b0;
    Out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e_in = 10'(10'h0A5 + 10'(k * 77));
      @(posedge clk_i); #1;
      In_valid_i = 1'b1; A_Mant_aligned_i = a_tab[k]; Product_i = p_tab[k];
      Sign_aligned_i = s_tab[k]; Sticky_i = st_tab[k]; Exp_aligned_i = e_in;
      @(negedge clk_i);
      checks++;
      if (In_ready_o !== 1'b1) begin
        fails++; $display("[TB] FAIL dir%0d_in_ready: got %b expected 1", k, In_ready_o);
      end
      @(posedge clk_i); #1;
      In_valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (Out_valid_o !== 1'b0) begin
        fails++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", k, Out_valid_o);
      end
      @(negedge clk_i);
      checks++;
      if (Out_valid_o !== 1'b1) begin
        fails++; $display("[TB] FAIL dir%0d_valid: got %b expected 1", k, Out_valid_o);
      end
      checks++;
      if (Mant_o !== m_exp[k]) begin
        fails++; $display("[TB] FAIL dir%0d_mant: got %h expected %h", k, Mant_o, m_exp[k]);
      end
      checks++;
      if (Lzc_o !== (LZC_ON ? l_exp[k] : 7'd0)) begin
        fails++; $display("[TB] FAIL dir%0d_lzc: got %0d expected %0d", k, Lzc_o, LZC_ON ? l_exp[k] : 7'd0);
      end
      checks++;
      if ({Sign_o, Zero_o, Sticky_o, Exp_o} !== {sg_exp[k], z_exp[k], st_tab[k], e_in}) begin
        fails++;
        $display("[TB] FAIL dir%0d_flags: got %h expected %h", k,
                 {Sign_o, Zero_o, Sticky_o, Exp_o}, {sg_exp[k], z_exp[k], st_tab[k], e_in});
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t beats[4];
    exp_t got;
    int   sent;
    int   done;
    logic exp_ready;
    logic [74:0] a_b[4];
    logic [47:0] p_b[4];
    logic [9:0]  e_b[4];
    for (int k = 0; k < 4; k++) begin
      gen_random();
      a_b[k] = A_Mant_aligned_i; p_b[k] = Product_i; e_b[k] = Exp_aligned_i;
      beats[k] = model(a_b[k], p_b[k], 1'b0, e_b[k], 1'b0);
    end
    sent = 0; done = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk_i); #1;
      Out_ready_i = (cyc >= 5);
      In_valid_i  = (sent < 4);
      if (sent < 4) begin
        A_Mant_aligned_i = a_b[sent]; Product_i = p_b[sent];
        Exp_aligned_i = e_b[sent]; Sign_aligned_i = 1'b0; Sticky_i = 1'b0;
      end
      @(negedge clk_i);
      exp_ready = !(q.size() == 2 && !Out_ready_i);
      checks++;
      if (In_ready_o !== exp_ready) begin
        fails++; $display("[TB] FAIL bp_in_ready c%0d: got %b expected %b", cyc, In_ready_o, exp_ready);
      end
      if (cyc == 4) begin
        checks++;
        if (sent != 2 || In_ready_o !== 1'b0) begin
          fails++; $display("[TB] FAIL bp_stall: got %0d beats ready=%b expected 2 beats ready=0", sent, In_ready_o);
        end
      end
      if (Out_valid_o === 1'b1) begin
        got = observed();
        checks++;
        if (q.size() == 0) begin
          fails++; $display("[TB] FAIL bp_spurious: got beat %h expected none", got);
        end else if (got !== q[0]) begin
          fails++; $display("[TB] FAIL bp_data c%0d: got %h expected %h", cyc, got, q[0]);
        end
        if (Out_ready_i && q.size() != 0) begin
          void'(q.pop_front());
          done++;
        end
      end
      if (In_valid_i && In_ready_o) begin
        q.push_back(beats[sent]);
        sent++;
      end
    end
    In_valid_i = 1'b0;
    checks++;
    if (done != 4 || q.size() != 0) begin
      fails++; $display("[TB] FAIL bp_count: got %0d beats out expected 4", done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t exp_b[8];
    exp_t got;
    Out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk_i); #1;
      In_valid_i = (cyc < 8);
      gen_random();
      if (cyc < 8) exp_b[cyc] = model(A_Mant_aligned_i, Product_i, Sign_aligned_i,
                                      Exp_aligned_i, Sticky_i);
      @(negedge clk_i);
      checks++;
      if (In_ready_o !== 1'b1) begin
        fails++; $display("[TB] FAIL b2b_in_ready c%0d: got %b expected 1", cyc, In_ready_o);
      end
      checks++;
      if (Out_valid_o !== (cyc >= 2 && cyc < 10)) begin
        fails++; $display("[TB] FAIL b2b_valid c%0d: got %b expected %b", cyc, Out_valid_o, (cyc >= 2 && cyc < 10));
      end else if (cyc >= 2 && cyc < 10) begin
        got = observed();
        checks++;
        if (got !== exp_b[cyc-2]) begin
          fails++; $display("[TB] FAIL b2b_data c%0d: got %h expected %h", cyc, got, exp_b[cyc-2]);
        end
      end
    end
    In_valid_i = 1'b0;
  endtask

  task automatic test_random_stream();
    exp_t q[$];
    exp_t got;
    logic exp_ready;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(posedge clk_i); #1;
      In_valid_i  = (cyc < 280) && ($urandom_range(0, 9) < 7);
      Out_ready_i = (cyc >= 280) || ($urandom_range(0, 9) < 6);
      gen_random();
      @(negedge clk_i);
      exp_ready = !(q.size() == 2 && !Out_ready_i);
      checks++;
      if (In_ready_o !== exp_ready) begin
        fails++; $display("[TB] FAIL rnd_in_ready c%0d: got %b expected %b", cyc, In_ready_o, exp_ready);
      end
      if (q.size() == 0) begin
        checks++;
        if (Out_valid_o !== 1'b0) begin
          fails++; $display("[TB] FAIL rnd_spurious c%0d: got valid %b expected 0", cyc, Out_valid_o);
        end
      end else if (Out_valid_o === 1'b1) begin
        got = observed();
        checks++;
        if (got !== q[0]) begin
          fails++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h", cyc, got, q[0]);
        end
        if (Out_ready_i) void'(q.pop_front());
      end
      if (In_valid_i && In_ready_o) begin
        q.push_back(model(A_Mant_aligned_i, Product_i, Sign_aligned_i, Exp_aligned_i, Sticky_i));
      end
    end
    In_valid_i = 1'b0;
    checks++;
    if (q.size() != 0) begin
      fails++; $display("[TB] FAIL rnd_drain: got %0d beats left expected 0", q.size());
    end
  endtask

  task automatic test_reset_midstream();
    exp_t want;
    exp_t got;
    Out_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i); #1;
      In_valid_i = 1'b1;
      gen_random();
    end
    @(posedge clk_i); #1;
    In_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (In_ready_o !== 1'b0 || Out_valid_o !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_full: got ready=%b valid=%b expected ready=0 valid=1", In_ready_o, Out_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({Out_valid_o, observed()} !== 95'd0) begin
      fails++; $display("[TB] FAIL rst_async: got %h expected 0", {Out_valid_o, observed()});
    end
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    Out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    In_valid_i = 1'b1;
    gen_random();
    want = model(A_Mant_aligned_i, Product_i, Sign_aligned_i, Exp_aligned_i, Sticky_i);
    @(posedge clk_i); #1;
    In_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (Out_valid_o !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_stale: got valid %b expected 0", Out_valid_o);
    end
    @(negedge clk_i);
    got = observed();
    checks++;
    if (Out_valid_o !== 1'b1 || got !== want) begin
      fails++; $display("[TB] FAIL rst_first_beat: got v=%b %h expected v=1 %h", Out_valid_o, got, want);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_i);
      checks++;
      if (Out_valid_o !== 1'b0) begin
        fails++; $display("[TB] FAIL rst_extra c%0d: got valid %b expected 0", cyc, Out_valid_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random_stream();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
